// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: takes a count N over a valid/ready handshake and builds a
// WIDTH-bit word holding exactly N ones, packed at the LSB end (in_align=0) or
// the MSB end (in_align=1). One '1' is shifted in per clock. The finished word
// is offered on a valid/ready output. Counts above WIDTH are clamped to WIDTH
// and flagged on the sticky sat_err.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   count request handshake; in_ready is high only in idle
//   in_count, in_align  requested number of ones, packing end
//   out_valid/out_ready pattern handshake; out_data is 0 unless out_valid
//   busy                high while filling or holding a finished pattern
//   sat_err             sticky: a request asked for more than WIDTH ones
//   chk_err             sticky: finished pattern popcount disagreed with the
//                       clamped request (only with the self-check build)
//
// Build option: define ONES_PATTERN_GEN_SELF_CHECK_EN to add the popcount
// self-check; otherwise chk_err is tied to 0.
module ones_pattern_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] in_count,
  input  logic             in_align,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             sat_err,
  output logic             chk_err
);

  localparam logic [DEPTH-1:0] WidthCnt = DEPTH'(WIDTH);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [DEPTH-1:0] rem_q, rem_d;
  logic             align_q, align_d;
  logic             sat_q, sat_d;
  logic [DEPTH-1:0] clamped;

  assign clamped = (in_count > WidthCnt) ? WidthCnt : in_count;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    align_d = align_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          align_d = in_align;
          rem_d   = clamped;
          shreg_d = '0;
          if (in_count > WidthCnt) sat_d = 1'b1;
          // A zero count has nothing to shift, so it finishes on the accept edge.
          state_d = (clamped == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        shreg_d = align_q ? {1'b1, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b1};
        rem_d   = rem_q - DEPTH'(1);
        if (rem_q == DEPTH'(1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          shreg_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      rem_q   <= '0;
      align_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      align_q <= align_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  // Mask the shift register so partially built patterns never leak out.
  assign out_data  = out_valid ? shreg_q : '0;
  assign sat_err   = sat_q;

`ifdef ONES_PATTERN_GEN_SELF_CHECK_EN
  logic [DEPTH-1:0] count_q, count_d;
  logic [DEPTH-1:0] popcnt;
  logic             chk_q, chk_d;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      popcnt = popcnt + DEPTH'(shreg_q[i]);
    end
  end

  always_comb begin
    count_d = count_q;
    chk_d   = chk_q;
    if (state_q == StIdle && in_valid) count_d = clamped;
    if (state_q == StDone && popcnt != count_q) chk_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      chk_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      chk_q   <= chk_d;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
module tb_ones_pattern_gen;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DEPTH-1:0] in_count;
  logic             in_align;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             sat_err;
  logic             chk_err;

  int n_vec = 0;
  int n_err = 0;

  ones_pattern_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_count (in_count),
    .in_align (in_align),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .sat_err  (sat_err),
    .chk_err  (chk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned count;
    logic        align;
    logic [31:0] exp_data;
    logic        exp_sat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference ones-counter standing in for a downstream generic_count_1.
  function automatic int unsigned count_ones(input logic [31:0] d);
    int unsigned c = 0;
    for (int i = 0; i < 32; i++) c += int'(d[i]);
    return c;
  endfunction

  // Present a request at negedge; returns once the accept edge has passed (+1).
  task automatic send_req(input int unsigned cnt, input logic al);
    @(negedge clk);
    check("in_ready_before_req", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_count = DEPTH'(cnt);
    in_align = al;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; expected latency is the
  // clamped count (a zero count is already done once the accept edge has passed).
  task automatic wait_done(input int unsigned exp_lat, input string tag);
    int unsigned lat = 0;
    logic busy_ok = 1'b1;
    logic mask_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (out_data != '0) mask_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_during_fill"}, {31'b0, busy_ok}, 32'd1);
    check({tag, "_partial_masked"}, {31'b0, mask_ok}, 32'd1);
  endtask

  task automatic take_output;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handshake_out_valid_low", {31'b0, out_valid}, 32'd0);
    check("handshake_in_ready_high", {31'b0, in_ready}, 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{5,  1'b0, 32'h0000001F, 1'b0};
    vecs[1] = '{3,  1'b1, 32'hE0000000, 1'b0};
    vecs[2] = '{0,  1'b0, 32'h00000000, 1'b0};
    vecs[3] = '{0,  1'b1, 32'h00000000, 1'b0};
    vecs[4] = '{32, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{1,  1'b1, 32'h80000000, 1'b0};
    vecs[6] = '{31, 1'b0, 32'h7FFFFFFF, 1'b0};
    vecs[7] = '{40, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{2,  1'b0, 32'h00000003, 1'b1};
    vecs[9] = '{33, 1'b1, 32'hFFFFFFFF, 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_count  = '0;
    in_align  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data",  out_data, 32'd0);
    check("reset_busy",      {31'b0, busy}, 32'd0);
    check("reset_in_ready",  {31'b0, in_ready}, 32'd1);
    check("reset_sat_err",   {31'b0, sat_err}, 32'd0);
    check("reset_chk_err",   {31'b0, chk_err}, 32'd0);
    // Requests while in reset must be ignored.
    in_valid = 1'b1;
    in_count = DEPTH'(4);
    @(posedge clk);
    #1;
    check("reset_ignores_req", {31'b0, busy}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      int unsigned clamp;
      clamp = (vecs[i].count > WIDTH) ? WIDTH : vecs[i].count;
      send_req(vecs[i].count, vecs[i].align);
      wait_done(clamp, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy_done", i), {31'b0, busy}, 32'd1);
      check($sformatf("vec%0d_sat_err", i), {31'b0, sat_err}, {31'b0, vecs[i].exp_sat});
      check($sformatf("vec%0d_chk_err", i), {31'b0, chk_err}, 32'd0);
      check($sformatf("vec%0d_loopback", i), count_ones(out_data), clamp);
      take_output();
    end

    // Backpressure: pattern held, second request ignored and not queued.
    send_req(4, 1'b0);
    wait_done(4, "bp");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      in_count = DEPTH'(7);
      check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
      check("bp_out_data_held",  out_data, 32'h0000000F);
      check("bp_in_ready_low",   {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_output();
    @(posedge clk);
    #1;
    check("bp_no_queued_req", {31'b0, busy}, 32'd0);

    // Reset seven edges into a long fill aborts everything immediately.
    send_req(20, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_out_data",  out_data, 32'd0);
    check("abort_busy",      {31'b0, busy}, 32'd0);
    check("abort_sat_clear", {31'b0, sat_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_req(1, 1'b0);
    wait_done(1, "post_abort");
    @(negedge clk);
    check("post_abort_data", out_data, 32'h00000001);
    check("post_abort_loopback", count_ones(out_data), 32'd1);
    take_output();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
